// File: rtl/pong_ball_ctrl_if.sv
// Ball datapath bus: position readback from the ball register, load/move strobes and
// step direction/magnitude from the sequencer.
interface pong_ball_ctrl_if;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic       ball_load;
   logic       ball_move;
   logic [5:0] vel_x;
   logic [5:0] vel_y;
   logic       dir_x;
   logic       dir_y;

   modport master (
      input  ball_x, ball_y,
      output ball_load, ball_move, vel_x, vel_y, dir_x, dir_y
   );

   modport slave (
      output ball_x, ball_y,
      input  ball_load, ball_move, vel_x, vel_y, dir_x, dir_y
   );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong game sequencer: serve/play/point/over flow, per-frame wall and paddle collisions, scores.
// Optional macro PONG_SPEEDUP_EN: each paddle hit raises vel_x by one, capped at MAX_VEL.
module pong_ball_ctrl #(
   parameter int unsigned SCREEN_W     = 640,
   parameter int unsigned SCREEN_H     = 480,
   parameter int unsigned BALL_W       = 8,
   parameter int unsigned PAD_L_X      = 16,
   parameter int unsigned PAD_R_X      = 616,
   parameter int unsigned PAD_W        = 8,
   parameter int unsigned PAD_H        = 64,
   parameter int unsigned VEL_X0       = 3,
   parameter int unsigned VEL_Y0       = 2,
   parameter int unsigned MAX_VEL      = 12,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned WIN_SCORE    = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             start,
   input  logic [8:0]       paddle_l_y,
   input  logic [8:0]       paddle_r_y,
   pong_ball_ctrl_if.master ball,
   output logic [3:0]       score_l,
   output logic [3:0]       score_r,
   output logic             game_over,
   output logic [2:0]       state
);

   localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);

   localparam logic [10:0] ScreenW = 11'(SCREEN_W);
   localparam logic [10:0] ScreenH = 11'(SCREEN_H);
   localparam logic [10:0] BallW   = 11'(BALL_W);
   localparam logic [10:0] PadLEdg = 11'(PAD_L_X + PAD_W);
   localparam logic [10:0] PadRX   = 11'(PAD_R_X);
   localparam logic [10:0] PadH    = 11'(PAD_H);
   localparam logic [5:0]  VelX0   = 6'(VEL_X0);
   localparam logic [5:0]  VelY0   = 6'(VEL_Y0);
   localparam logic [5:0]  MaxVel  = 6'(MAX_VEL);
   localparam logic [3:0]  WinSc   = 4'(WIN_SCORE);
`ifdef PONG_SPEEDUP_EN
   localparam logic [5:0]  VelStep = 6'd1;
`else
   localparam logic [5:0]  VelStep = 6'd0;
`endif

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StServe = 3'd1,
      StPlay  = 3'd2,
      StPoint = 3'd3,
      StOver  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        score_l_q, score_l_d;
   logic [3:0]        score_r_q, score_r_d;
   logic              dir_x_q, dir_x_d;
   logic              dir_y_q, dir_y_d;
   logic [5:0]        vel_x_q, vel_x_d;
   logic [CntW-1:0]   serve_cnt_q, serve_cnt_d;
   logic              ball_load_q, ball_load_d;
   logic              ball_move_q, ball_move_d;
   logic              left_scored_q, left_scored_d;

   logic [10:0] bx, by, vx, vy, pl, pr;
   logic        top_hit, bot_hit, ovl_l, ovl_r, l_hit, r_hit, l_miss, r_miss;
   logic [5:0]  vel_sum, vel_hit;

   assign bx = {1'b0, ball.ball_x};
   assign by = {2'b0, ball.ball_y};
   assign vx = {5'b0, vel_x_q};
   assign vy = {5'b0, VelY0};
   assign pl = {2'b0, paddle_l_y};
   assign pr = {2'b0, paddle_r_y};

   assign top_hit = dir_y_q && (by <= vy);
   assign bot_hit = !dir_y_q && (by + BallW + vy >= ScreenH);
   assign ovl_l   = (by + BallW > pl) && (by < pl + PadH);
   assign ovl_r   = (by + BallW > pr) && (by < pr + PadH);
   assign l_hit   = dir_x_q && (bx <= PadLEdg + vx) && ovl_l;
   assign r_hit   = !dir_x_q && (bx + BallW + vx >= PadRX) && ovl_r;
   assign l_miss  = dir_x_q && !l_hit && (bx < vx);
   assign r_miss  = !dir_x_q && !r_hit && (bx + BallW + vx > ScreenW);

   assign vel_sum = vel_x_q + VelStep;
   assign vel_hit = (vel_sum > MaxVel) ? MaxVel : vel_sum;

   always_comb begin
      state_d       = state_q;
      score_l_d     = score_l_q;
      score_r_d     = score_r_q;
      dir_x_d       = dir_x_q;
      dir_y_d       = dir_y_q;
      vel_x_d       = vel_x_q;
      serve_cnt_d   = serve_cnt_q;
      ball_load_d   = 1'b0;
      ball_move_d   = 1'b0;
      left_scored_d = left_scored_q;

      case (state_q)
         StIdle: begin
            if (start) state_d = StServe;
         end
         StServe: begin
            if (frame_tick) begin
               if (serve_cnt_q == CntW'(SERVE_FRAMES - 1)) state_d = StPlay;
               else serve_cnt_d = serve_cnt_q + 1'b1;
            end
         end
         StPlay: begin
            if (frame_tick) begin
               if (top_hit) dir_y_d = 1'b0;
               if (bot_hit) dir_y_d = 1'b1;
               if (l_hit) begin
                  dir_x_d = 1'b0;
                  vel_x_d = vel_hit;
               end else if (r_hit) begin
                  dir_x_d = 1'b1;
                  vel_x_d = vel_hit;
               end
               // Serve heads toward whoever conceded.
               if (l_miss) begin
                  score_r_d     = (score_r_q == 4'hF) ? 4'hF : score_r_q + 4'd1;
                  dir_x_d       = 1'b1;
                  left_scored_d = 1'b0;
                  state_d       = StPoint;
               end else if (r_miss) begin
                  score_l_d     = (score_l_q == 4'hF) ? 4'hF : score_l_q + 4'd1;
                  dir_x_d       = 1'b0;
                  left_scored_d = 1'b1;
                  state_d       = StPoint;
               end else begin
                  ball_move_d = 1'b1;
               end
            end
         end
         StPoint: begin
            if ((left_scored_q ? score_l_q : score_r_q) == WinSc) state_d = StOver;
            else state_d = StServe;
         end
         StOver: begin
            if (start) begin
               score_l_d = 4'd0;
               score_r_d = 4'd0;
               state_d   = StServe;
            end
         end
         default: state_d = StIdle;
      endcase

      // Entering SERVE: recentre once, restore serve speed, restart the frame count.
      if (state_d == StServe && state_q != StServe) begin
         ball_load_d = 1'b1;
         vel_x_d     = VelX0;
         serve_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         score_l_q     <= 4'd0;
         score_r_q     <= 4'd0;
         dir_x_q       <= 1'b0;
         dir_y_q       <= 1'b0;
         vel_x_q       <= VelX0;
         serve_cnt_q   <= '0;
         ball_load_q   <= 1'b0;
         ball_move_q   <= 1'b0;
         left_scored_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         score_l_q     <= score_l_d;
         score_r_q     <= score_r_d;
         dir_x_q       <= dir_x_d;
         dir_y_q       <= dir_y_d;
         vel_x_q       <= vel_x_d;
         serve_cnt_q   <= serve_cnt_d;
         ball_load_q   <= ball_load_d;
         ball_move_q   <= ball_move_d;
         left_scored_q <= left_scored_d;
      end
   end

   assign ball.ball_load = ball_load_q;
   assign ball.ball_move = ball_move_q;
   assign ball.vel_x     = vel_x_q;
   assign ball.vel_y     = VelY0;
   assign ball.dir_x     = dir_x_q;
   assign ball.dir_y     = dir_y_q;
   assign score_l        = score_l_q;
   assign score_r        = score_r_q;
   assign game_over      = (state_q == StOver);
   assign state          = state_q;

endmodule
